// File: rtl/hazard_forward_ctrl_pkg.sv
// hazard_forward_ctrl_pkg: shared types for the EX-stage hazard and forwarding controller
package hazard_forward_ctrl_pkg;
  localparam int RA_W_DEF = 4;
  typedef enum logic [1:0] {
    SEL_REG = 2'd0,
    SEL_MEM = 2'd1,
    SEL_WB  = 2'd2
  } fwd_sel_t;
  typedef struct packed {
    logic                valid;
    logic [RA_W_DEF-1:0] rd;
    logic                we;
    logic                is_load;
  } pipe_rec_t;
endpackage

// File: rtl/hazard_forward_ctrl_match.sv
// hazard_match: compares one source register against the EX and MEM records
module hazard_match
  import hazard_forward_ctrl_pkg::*;
(
  input  logic [RA_W_DEF-1:0] src,
  input  logic                use_src,
  input  pipe_rec_t           ex_rec,
  input  pipe_rec_t           mem_rec,
  output fwd_sel_t            sel,
  output logic                load_hit
);
  logic hit_ex, hit_mem;
  always_comb begin
    hit_ex   = use_src && src != '0 && ex_rec.valid && ex_rec.we && ex_rec.rd == src;
    hit_mem  = use_src && src != '0 && mem_rec.valid && mem_rec.we && mem_rec.rd == src;
    load_hit = hit_ex && ex_rec.is_load;
    sel      = hit_ex ? SEL_MEM : hit_mem ? SEL_WB : SEL_REG;
  end
endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: load-use stall, branch flush and registered operand-forwarding selects for EX
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rs_st,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_use_st,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             ex_busy,
  input  logic             ex_branch_taken,
  output logic [1:0]       reg1_sel,
  output logic [1:0]       reg2_sel,
  output logic [1:0]       ST_reg_sel,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  // The register file writes before it reads, so nothing past MEM needs tracking for forwarding.
  pipe_rec_t ex_rec, mem_rec, id_rec;
  fwd_sel_t  sel1, sel2, sel_st;
  logic      lh1, lh2, lh_st, load_use, lu_stall, accept;
  hazard_match u_m1 (.src(id_rs1), .use_src(id_use_rs1), .ex_rec(ex_rec), .mem_rec(mem_rec), .sel(sel1), .load_hit(lh1));
  hazard_match u_m2 (.src(id_rs2), .use_src(id_use_rs2), .ex_rec(ex_rec), .mem_rec(mem_rec), .sel(sel2), .load_hit(lh2));
  hazard_match u_ms (.src(id_rs_st), .use_src(id_use_st), .ex_rec(ex_rec), .mem_rec(mem_rec), .sel(sel_st), .load_hit(lh_st));
  always_comb begin
    id_rec   = '{valid: 1'b1, rd: id_rd, we: id_we, is_load: id_is_load};
    load_use = id_valid && (lh1 || lh2 || lh_st);
    flush    = rst_n && !ex_busy && ex_branch_taken;
    lu_stall = rst_n && !ex_busy && !ex_branch_taken && load_use;
    stall    = (rst_n && ex_busy) || lu_stall;
    bubble   = flush || lu_stall;
    accept   = id_valid && !bubble;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rec     <= '0;
      mem_rec    <= '0;
      reg1_sel   <= SEL_REG;
      reg2_sel   <= SEL_REG;
      ST_reg_sel <= SEL_REG;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      if (!ex_busy) begin
        mem_rec    <= ex_rec;
        ex_rec     <= accept ? id_rec : '0;
        reg1_sel   <= accept ? sel1 : SEL_REG;
        reg2_sel   <= accept ? sel2 : SEL_REG;
        ST_reg_sel <= accept ? sel_st : SEL_REG;
      end
      if (lu_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule
